// File: rtl/crack_sequencer_pkg.sv
// crack_sequencer_pkg: crack-kind encodings, opcode/XO constants and field slices for the crack sequencer.
package crack_sequencer_pkg;
  typedef enum logic [1:0] {K_PASS = 2'd0, K_UPDATE = 2'd1, K_MULTI = 2'd2, K_RSVD = 2'd3} kind_e;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;
  localparam logic [5:0] OP_X    = 6'd31;
  localparam logic [5:0] OP_LWZU = 6'd33;
  localparam logic [5:0] OP_LBZU = 6'd35;
  localparam logic [5:0] OP_STWU = 6'd37;
  localparam logic [5:0] OP_STBU = 6'd39;
  localparam logic [5:0] OP_LHZU = 6'd41;
  localparam logic [5:0] OP_LHAU = 6'd43;
  localparam logic [5:0] OP_STHU = 6'd45;
  localparam logic [5:0] OP_LMW  = 6'd46;
  localparam logic [5:0] OP_STMW = 6'd47;
  localparam logic [5:0] OP_LDU  = 6'd58;
  localparam logic [5:0] OP_STDU = 6'd62;
  localparam logic [9:0] XO_LDUX  = 10'd53;
  localparam logic [9:0] XO_LWZUX = 10'd55;
  localparam logic [9:0] XO_LBZUX = 10'd119;
  localparam logic [9:0] XO_STDUX = 10'd181;
  localparam logic [9:0] XO_STWUX = 10'd183;
  localparam logic [9:0] XO_STBUX = 10'd247;
  localparam logic [9:0] XO_LHZUX = 10'd311;
  localparam logic [9:0] XO_LWAUX = 10'd373;
  localparam logic [9:0] XO_LHAUX = 10'd375;
  localparam logic [9:0] XO_STHUX = 10'd439;
  localparam logic [1:0] DS_UPD   = 2'b01;
  // IBM bit numbering: bit 0 is the MSB, so instr[0:5] is [31:26] here
  function automatic logic [5:0] op_of(input logic [31:0] i);
    return i[31:26];
  endfunction
  function automatic logic [4:0] rt_of(input logic [31:0] i);
    return i[25:21];
  endfunction
  function automatic logic [4:0] ra_of(input logic [31:0] i);
    return i[20:16];
  endfunction
  function automatic logic [9:0] xo_of(input logic [31:0] i);
    return i[10:1];
  endfunction
endpackage

// File: rtl/crack_classify.sv
// crack_classify: combinational decode of an instruction into crack kind, RT and illegal-form flag.
// Illegal-form checking is enabled by CRACK_ILLEGAL_CHK_EN.
module crack_classify
  import crack_sequencer_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  kind,
  output logic [4:0]  rt,
  output logic        illegal
);
  logic [5:0] op;
  logic [9:0] xo;
  logic [4:0] ra;
  logic       ds_upd, upd_ld, upd, multi;
  logic       unused_d;
  assign op       = op_of(instr);
  assign xo       = xo_of(instr);
  assign rt       = rt_of(instr);
  assign ra       = ra_of(instr);
  assign ds_upd   = instr[1:0] == DS_UPD;
  assign unused_d = ^instr[15:11];
  assign upd_ld = (op inside {OP_LWZU, OP_LBZU, OP_LHZU, OP_LHAU}) || (op == OP_LDU && ds_upd) ||
                  (op == OP_X && (xo inside {XO_LWZUX, XO_LBZUX, XO_LHZUX, XO_LHAUX, XO_LDUX, XO_LWAUX}));
  assign upd = upd_ld || (op inside {OP_STWU, OP_STBU, OP_STHU}) || (op == OP_STDU && ds_upd) ||
               (op == OP_X && (xo inside {XO_STWUX, XO_STBUX, XO_STHUX, XO_STDUX}));
  assign multi = op == OP_LMW || op == OP_STMW;
`ifdef CRACK_ILLEGAL_CHK_EN
  assign illegal = (upd && (ra == 5'd0 || (upd_ld && ra == rt))) || (multi && ra != 5'd0 && ra >= rt);
`else
  logic unused_ra;
  assign unused_ra = ^ra;
  assign illegal   = 1'b0;
`endif
  // an illegal form issues as one PASS slot so decode can raise the exception
  assign kind = illegal ? K_PASS : upd ? K_UPDATE : multi ? K_MULTI : K_PASS;
endmodule

// File: rtl/crack_sequencer.sv
// crack_sequencer: holds one fetched instruction and issues its micro-op slots to decode.
// Optional CRACK_ILLEGAL_CHK_EN turns on illegal-form detection inside crack_classify.
module crack_sequencer
  import crack_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [1:0]             out_kind,
  output logic [4:0]             out_step,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   out_illegal,
  output logic                   fetch_hold
);
  state_e     state, state_nx;
  logic [1:0] c_kind;
  logic [4:0] c_rt, rt_q;
  logic       c_ill, fire, accept;
  crack_classify u_classify (
    .instr   (in_instr[31:0]),
    .kind    (c_kind),
    .rt      (c_rt),
    .illegal (c_ill)
  );
  // RT+step never exceeds 31 for a legal schedule, so a 6-bit sum compare is exact
  assign out_last = out_kind == K_UPDATE ? out_step == 5'd1 :
                    out_kind == K_MULTI  ? ({1'b0, rt_q} + {1'b0, out_step}) == 6'd31 : 1'b1;
  assign out_first  = out_step == 5'd0;
  assign out_valid  = state == ISSUE && !flush;
  assign fire       = out_valid && out_ready;
  assign in_ready   = !flush && (state == IDLE || (fire && out_last));
  assign accept     = in_valid && in_ready;
  assign fetch_hold = !in_ready;
  always_comb begin
    state_nx = state;
    state_nx = flush ? IDLE : accept ? ISSUE : (fire && out_last) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_pc      <= '0;
      out_instr   <= '0;
      out_kind    <= K_PASS;
      out_step    <= '0;
      out_illegal <= 1'b0;
      rt_q        <= '0;
    end else if (flush) begin
      out_step <= '0;
    end else if (accept) begin
      out_pc      <= in_pc;
      out_instr   <= in_instr;
      out_kind    <= c_kind;
      out_step    <= '0;
      out_illegal <= c_ill;
      rt_q        <= c_rt;
    end else if (fire) begin
      out_step <= out_last ? 5'd0 : out_step + 5'd1;
    end
endmodule

// File: tb/tb_crack_sequencer.sv
// tb_crack_sequencer: directed plan cases plus random traffic against a slot-queue reference model.
module tb_crack_sequencer;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_instr = '0;
  logic        in_ready, out_valid, out_first, out_last, out_illegal, fetch_hold;
  logic [31:0] out_pc, out_instr;
  logic [1:0]  out_kind;
  logic [4:0]  out_step;
  typedef struct {
    logic [31:0] pc, instr;
    logic [1:0]  kind;
    logic [4:0]  step;
    logic        last, ill;
  } slot_t;
  slot_t       q[$];
  int          n_chk = 0, n_pass = 0;
  logic [31:0] pc_ctr = 32'h1000;
  crack_sequencer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_kind(out_kind), .out_step(out_step),
    .out_first(out_first), .out_last(out_last), .out_illegal(out_illegal), .fetch_hold(fetch_hold)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [31:0] mk(input int op, input int rt, input int ra, input logic [15:0] lo);
    return {op[5:0], rt[4:0], ra[4:0], lo};
  endfunction
  // reference model: expand an accepted instruction into its full list of expected slots
  function automatic void push_instr(input logic [31:0] pc, input logic [31:0] ins);
    int op, rt, ra, xo, ds, n, kind;
    bit upd, ld, mul, ill;
    slot_t s;
    op = ins[31:26]; rt = ins[25:21]; ra = ins[20:16]; xo = ins[10:1]; ds = ins[1:0];
    ld  = (op inside {33, 35, 41, 43}) || (op == 58 && ds == 1) ||
          (op == 31 && (xo inside {55, 119, 311, 375, 53, 373}));
    upd = ld || (op inside {37, 39, 45}) || (op == 62 && ds == 1) ||
          (op == 31 && (xo inside {183, 247, 439, 181}));
    mul = op == 46 || op == 47;
    ill = 0;
`ifdef CRACK_ILLEGAL_CHK_EN
    ill = (upd && ra == 0) || (upd && ld && ra == rt) || (mul && ra != 0 && ra >= rt);
`endif
    n    = ill ? 1 : upd ? 2 : mul ? 32 - rt : 1;
    kind = ill ? 0 : upd ? 1 : mul ? 2 : 0;
    for (int k = 0; k < n; k++) begin
      s.pc = pc; s.instr = ins; s.kind = kind[1:0]; s.step = k[4:0]; s.last = k == n - 1; s.ill = ill;
      q.push_back(s);
    end
  endfunction
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl, output logic acc);
    logic ev, er;
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #2;
    ev = !fl && q.size() > 0;
    er = !fl && (q.size() == 0 || (ev && ordy && q[0].last));
    check("out_valid", out_valid, ev);
    check("in_ready", in_ready, er);
    check("fetch_hold", fetch_hold, !er);
    if (ev) begin
      check("out_pc", out_pc, q[0].pc);
      check("out_instr", out_instr, q[0].instr);
      check("out_kind", out_kind, q[0].kind);
      check("out_step", out_step, q[0].step);
      check("out_first", out_first, q[0].step == 0);
      check("out_last", out_last, q[0].last);
      check("out_illegal", out_illegal, q[0].ill);
    end
    acc = iv && in_ready;
    if (fl) q.delete();
    else begin
      if (ev && ordy) void'(q.pop_front());
      if (iv && er) push_instr(pc, ins);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] ins, input logic ordy);
    logic acc;
    int n;
    acc = 0; n = 0;
    while (!acc && n < 100) begin
      cyc(1'b1, ins, pc_ctr, ordy, 1'b0, acc);
      n++;
    end
    check("accept_timeout", acc, 1'b1);
    pc_ctr += 4;
  endtask
  task automatic idle_cyc(input logic ordy, input logic fl);
    logic acc;
    cyc(1'b0, 32'h0, 32'h0, ordy, fl, acc);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 64) begin
      idle_cyc(1'b1, 1'b0);
      n++;
    end
    check("drain_timeout", q.size(), 0);
    idle_cyc(1'b1, 1'b0);
  endtask
  function automatic logic [31:0] rand_instr();
    int rt, ra, sel;
    logic [15:0] lo;
    int dops[7] = '{33, 35, 37, 39, 41, 43, 45};
    int xos[10] = '{55, 119, 183, 247, 311, 375, 439, 53, 181, 373};
    rt = $urandom_range(0, 31); ra = $urandom_range(0, 31); lo = 16'($urandom);
    sel = $urandom_range(0, 5);
    case (sel)
      0: return $urandom;
      1: return mk(dops[$urandom_range(0, 6)], rt, ra, lo);
      2: return mk(31, rt, ra, {lo[15:11], xos[$urandom_range(0, 9)][9:0], 1'b0});
      3: return mk($urandom_range(0, 1) ? 58 : 62, rt, ra, {lo[15:2], $urandom_range(0, 3) ? 2'b01 : lo[1:0]});
      4: return mk($urandom_range(46, 47), $urandom_range(0, 3) ? $urandom_range(22, 31) : rt,
                   $urandom_range(0, 1) ? 0 : ra, lo);
      default: return mk(dops[$urandom_range(0, 6)], rt, $urandom_range(0, 1) ? 0 : rt, lo);
    endcase
  endfunction
  initial begin
    logic acc;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_step", out_step, 5'd0);
    check("rst_out_kind", out_kind, 2'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_illegal", out_illegal, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) send(mk(14, 3, 1, 16'(i)), 1'b1);
    drain();
    send(mk(33, 5, 3, 16'd8), 1'b1);
    send(mk(14, 4, 4, 16'd1), 1'b1);
    drain();
    send(mk(46, 29, 1, 16'd0), 1'b1);
    idle_cyc(1'b1, 1'b0);
    idle_cyc(1'b0, 1'b0);
    idle_cyc(1'b1, 1'b0);
    idle_cyc(1'b1, 1'b0);
    check("lmw_done", q.size(), 0);
    drain();
    send(mk(47, 0, 0, 16'd0), 1'b1);
    drain();
    send(mk(46, 28, 1, 16'd0), 1'b1);
    idle_cyc(1'b1, 1'b0);
    idle_cyc(1'b1, 1'b1);
    check("flush_step", out_step, 5'd0);
    check("flush_idle", out_valid, 1'b0);
    send(mk(14, 6, 0, 16'd7), 1'b1);
    drain();
    send(mk(33, 3, 3, 16'd4), 1'b1);
    drain();
    for (int i = 0; i < 2500; i++)
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 3) != 0,
          $urandom_range(0, 40) == 0, acc);
    idle_cyc(1'b0, 1'b1);
    send(mk(47, 0, 0, 16'd0), 1'b1);
    repeat (3) idle_cyc(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_step", out_step, 5'd0);
    check("midrst_kind", out_kind, 2'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    send(mk(14, 8, 2, 16'd3), 1'b1);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
